ws2812_frame_sequencer: RTL and testbench
=========================================

# ws2812_frame_sequencer

Frame-level controller between the pixel color array produced by the pattern generators and the WS2812 bit encoder. On a start request, or on an optional periodic refresh tick, it walks every pixel of every bank in order. Each pixel is handed to the encoder over a valid/ready handshake in GRB order. After the last pixel it holds the chain in the WS2812 latch (reset) gap, then reports frame completion.

## Interface
Parameters:
- CLKHZ, 32'd100_000_000, system clock frequency in Hz
- BANK_NUM, 1, number of LED banks
- BANK_X, 8, pixels per bank row
- BANK_Y, 8, rows per bank
- LATCH_US, 300, latch gap length in µs; LATCH_CYCLES = CLKHZ/1_000_000*LATCH_US
- REFRESH_MS, 0, auto-refresh period in ms; 0 disables auto-refresh

Ports:
- clk  in  1  system clock; single clock domain
- rst  in  1  synchronous, active-high reset
- wscolor  in  24 x (BANK_NUM*BANK_X*BANK_Y)  per-pixel color, {R,G,B}, index = x + BANK_X*y + bank*BANK_X*BANK_Y
- start  in  1  one-cycle frame request
- pix_valid  out  1  pixel word valid toward encoder
- pix_ready  in  1  encoder accepts pixel
- pix_data  out  24  {G,R,B} of current pixel
- pix_bank  out  clog2(BANK_NUM) (min 1)  bank of current pixel
- pix_last  out  1  current pixel is last of its bank
- latch  out  1  high throughout the latch gap
- busy  out  1  high in any state except IDLE
- frame_done  out  1  one-cycle pulse at end of frame

## Operation
- States: IDLE, LOAD, SEND, LATCH, DONE.
- IDLE: waits for a trigger. A trigger is start=1 or a pending refresh flag. On a trigger: idx<=0, go to LOAD.
- LOAD:
  - Registers pix_data <= {wscolor[idx][15:8], wscolor[idx][23:16], wscolor[idx][7:0]}.
  - Registers pix_bank <= idx / (BANK_X*BANK_Y).
  - Sets pix_last when idx mod (BANK_X*BANK_Y) == BANK_X*BANK_Y-1.
  - Sets pix_valid<=1, then goes to SEND.
- SEND:
  - While pix_valid && !pix_ready, pix_data, pix_bank and pix_last hold stable. Later changes to wscolor do not affect the word already loaded.
  - On a handshake (pix_valid && pix_ready): pix_valid<=0.
  - If idx == total-1, go to LATCH with the counter cleared. Otherwise idx<=idx+1 and go to LOAD.
- LATCH: latch=1 for exactly LATCH_CYCLES cycles, then go to DONE.
- DONE: frame_done=1 for one cycle, then go to IDLE.
- Trigger rules:
  - start while busy: ignored, not queued.
  - Refresh tick (REFRESH_MS>0): sets the pending flag. The flag clears when IDLE consumes it.
  - Ticks arriving while the flag is already set are merged into one.
  - start and the pending flag in the same IDLE cycle produce one frame, and the flag is cleared.
- Widths:
  - idx is clog2(total) bits.
  - The latch counter is clog2(LATCH_CYCLES+1) bits.
  - Division and modulo in LOAD are computed by a bank/pixel counter pair, not a divider.
- Reset at any time, including mid-frame:
  - State goes to IDLE.
  - idx, latch counter and pending flag clear.
  - All outputs are 0.
  - The encoder sees pix_valid drop in the cycle after rst is sampled.

## Timing
- Reset values: pix_valid=0, pix_data=0, pix_bank=0, pix_last=0, latch=0, busy=0, frame_done=0.
- start sampled high in IDLE at cycle T:
  - busy=1 at T+1.
  - pix_valid=1 with pixel 0 at T+2.
- Each pixel costs 1 LOAD cycle plus ≥1 SEND cycle. With pix_ready tied high, a frame takes 2*total cycles of pixels.
- The last handshake happens at cycle H:
  - latch=1 from H+1 through H+LATCH_CYCLES.
  - frame_done=1 and busy=1 at H+LATCH_CYCLES+1.
  - busy=0 at H+LATCH_CYCLES+2.
- The earliest next frame start is the cycle busy returns to 0.

## Structure
- Package ws2812_pkg holds:
  - the state enum (IDLE, LOAD, SEND, LATCH, DONE);
  - the rgb_to_grb function;
  - the latch_cycles(clkhz, us) constant function.
- Sub-module: the existing timingDivider, instantiated only when REFRESH_MS>0, with OUTPUTCLKms=REFRESH_MS. Its tick sets the pending flag.
- Everything else stays in one module of about 200 lines.

## Test plan
- Config CLKHZ=10_000_000, LATCH_US=5 (50 cycles), BANK_NUM=2, 2x2. Pulse start with pix_ready=1 and wscolor[i]=24'h010203*(i+1). Required response:
  - 8 words, first 24'h020103.
  - pix_bank is 0,0,0,0,1,1,1,1.
  - pix_last is set on idx 3 and 7.
  - latch is high for exactly 50 cycles.
  - frame_done pulses once.
- Backpressure: pix_ready low for 7 cycles on pixel 2 -> pix_data stable and pix_valid held for all 7 cycles; no pixel dropped or duplicated.
- start re-pulsed during SEND and during LATCH -> ignored; exactly one frame_done.
- Change wscolor[0] to 24'hFFFFFF one cycle after pixel 0 is loaded, while it is held -> output word is unchanged.
- rst asserted mid-frame at pixel 3:
  - all outputs 0 the next cycle;
  - no frame_done;
  - a following start sends from pixel 0.
- REFRESH_MS=1 at CLKHZ=10 MHz -> a frame starts every 10_000 cycles. A tick arriving during a frame is serviced immediately after DONE, and only once.

Source files
------------

// File: rtl/ws2812_pkg.sv
// Purpose: shared types and helpers for the WS2812 frame sequencer.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package ws2812_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SEND  = 3'd2,
        LATCH = 3'd3,
        DONE  = 3'd4
    } state_e;

    // Pixel arrays hold {R,G,B}; the WS2812 wire order is G first.
    function automatic logic [23:0] rgb_to_grb(input logic [23:0] rgb);
        return {rgb[15:8], rgb[23:16], rgb[7:0]};
    endfunction

    // Cycles in a latch gap of 'us' microseconds at 'clkhz'.
    function automatic int latch_cycles(input logic [31:0] clkhz, input int us);
        return int'(clkhz / 32'd1_000_000) * us;
    endfunction

endpackage

// File: rtl/timingDivider.sv
// Purpose: free-running divider emitting a one-cycle tick every OUTPUTCLKms milliseconds.
// Latency: first tick OUTPUTCLKms ms after reset release, then strictly periodic.
// Backpressure: none; the tick is a pulse and must be captured by the consumer.
// Ports: clk, rst (sync, active-high), tick (one-cycle pulse).
module timingDivider #(
    parameter logic [31:0] CLKHZ       = 32'd100_000_000,
    parameter int          OUTPUTCLKms = 1
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int PERIOD = int'(CLKHZ / 32'd1000) * OUTPUTCLKms;
    localparam int CW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [CW-1:0] cnt_q;
    logic          tick_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else if (cnt_q == CW'(PERIOD - 1)) begin
            cnt_q  <= '0;
            tick_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_q + 1'b1;
            tick_q <= 1'b0;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/ws2812_frame_sequencer.sv
// Purpose: walks every pixel of every bank and hands GRB words to the WS2812 encoder, then holds the latch gap.
// Latency: start in IDLE at T -> busy at T+1, first word valid at T+2; each pixel costs 1 LOAD + >=1 SEND cycle.
// Backpressure: pix_valid/pix_ready; the loaded word is held stable until accepted, start while busy is dropped.
// Ports: clk/rst; wscolor pixel array {R,G,B}; start; pix_valid/pix_ready/pix_data/pix_bank/pix_last toward
//        the encoder; latch (gap active), busy (not IDLE), frame_done (one-cycle end-of-frame pulse).
module ws2812_frame_sequencer
    import ws2812_pkg::*;
#(
    parameter logic [31:0] CLKHZ      = 32'd100_000_000,
    parameter int          BANK_NUM   = 1,
    parameter int          BANK_X     = 8,
    parameter int          BANK_Y     = 8,
    parameter int          LATCH_US   = 300,
    parameter int          REFRESH_MS = 0
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [BANK_NUM*BANK_X*BANK_Y-1:0][23:0]       wscolor,
    input  logic                                          start,
    output logic                                          pix_valid,
    input  logic                                          pix_ready,
    output logic [23:0]                                   pix_data,
    output logic [((BANK_NUM > 1) ? $clog2(BANK_NUM) : 1)-1:0] pix_bank,
    output logic                                          pix_last,
    output logic                                          latch,
    output logic                                          busy,
    output logic                                          frame_done
);
    localparam int PPB    = BANK_X * BANK_Y;
    localparam int TOTAL  = BANK_NUM * PPB;
    localparam int IDX_W  = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam int PIB_W  = (PPB > 1) ? $clog2(PPB) : 1;
    localparam int BANK_W = (BANK_NUM > 1) ? $clog2(BANK_NUM) : 1;
    localparam int LC     = latch_cycles(CLKHZ, LATCH_US);
    localparam int LC_W   = $clog2(LC + 1);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [PIB_W-1:0]    pib_q, pib_d;      // pixel within bank (idx mod PPB)
    logic [BANK_W-1:0]   bank_q, bank_d;    // bank index (idx / PPB)
    logic [LC_W-1:0]     lcnt_q, lcnt_d;
    logic                pend_q, pend_d;
    logic                valid_q, valid_d;
    logic [23:0]         data_q, data_d;
    logic [BANK_W-1:0]   obank_q, obank_d;
    logic                last_q, last_d;
    logic                refresh_tick;
    logic                hs;

    generate
        if (REFRESH_MS > 0) begin : g_refresh
            timingDivider #(
                .CLKHZ      (CLKHZ),
                .OUTPUTCLKms(REFRESH_MS)
            ) u_refresh (
                .clk (clk),
                .rst (rst),
                .tick(refresh_tick)
            );
        end else begin : g_no_refresh
            assign refresh_tick = 1'b0;
        end
    endgenerate

    assign hs = valid_q & pix_ready;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pib_d   = pib_q;
        bank_d  = bank_q;
        lcnt_d  = lcnt_q;
        // A tick always lands in the flag, so one arriving on the consuming cycle is not lost.
        pend_d  = pend_q | refresh_tick;
        valid_d = valid_q;
        data_d  = data_q;
        obank_d = obank_q;
        last_d  = last_q;

        case (state_q)
            IDLE: begin
                if (start || pend_q) begin
                    state_d = LOAD;
                    idx_d   = '0;
                    pib_d   = '0;
                    bank_d  = '0;
                    pend_d  = refresh_tick;
                end
            end
            LOAD: begin
                data_d  = rgb_to_grb(wscolor[idx_q]);
                obank_d = bank_q;
                last_d  = (pib_q == PIB_W'(PPB - 1));
                valid_d = 1'b1;
                state_d = SEND;
            end
            SEND: begin
                if (hs) begin
                    valid_d = 1'b0;
                    if (idx_q == IDX_W'(TOTAL - 1)) begin
                        state_d = LATCH;
                        lcnt_d  = '0;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = LOAD;
                        if (pib_q == PIB_W'(PPB - 1)) begin
                            pib_d  = '0;
                            bank_d = bank_q + 1'b1;
                        end else begin
                            pib_d  = pib_q + 1'b1;
                        end
                    end
                end
            end
            LATCH: begin
                if (lcnt_q == LC_W'(LC - 1)) begin
                    lcnt_d  = '0;
                    state_d = DONE;
                end else begin
                    lcnt_d  = lcnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            pib_q   <= '0;
            bank_q  <= '0;
            lcnt_q  <= '0;
            pend_q  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            obank_q <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pib_q   <= pib_d;
            bank_q  <= bank_d;
            lcnt_q  <= lcnt_d;
            pend_q  <= pend_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            obank_q <= obank_d;
            last_q  <= last_d;
        end
    end

    assign pix_valid  = valid_q;
    assign pix_data   = data_q;
    assign pix_bank   = obank_q;
    assign pix_last   = last_q;
    assign latch      = (state_q == LATCH);
    assign busy       = (state_q != IDLE);
    assign frame_done = (state_q == DONE);

endmodule

// File: tb/tb_ws2812_frame_sequencer.sv
module tb_ws2812_frame_sequencer;

    typedef struct {
        int          stall;   // cycles pix_ready is held low on this pixel (stalling frames only)
        logic [23:0] data;
        logic        bank;
        logic        last;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [7:0][23:0] wscolor;
    logic             start = 1'b0;
    logic             pix_ready = 1'b1;
    logic             pix_valid, pix_last, latch, busy, frame_done;
    logic [23:0]      pix_data;
    logic [0:0]       pix_bank;

    logic             start_r = 1'b0;
    logic             pix_valid_r, pix_last_r, latch_r, busy_r, frame_done_r;
    logic [23:0]      pix_data_r;
    logic [0:0]       pix_bank_r;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_r_cnt = 0;
    vec_t tab [8];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (frame_done)   done_cnt++;
        if (frame_done_r) done_r_cnt++;
    end

    ws2812_frame_sequencer #(
        .CLKHZ(32'd10_000_000), .BANK_NUM(2), .BANK_X(2), .BANK_Y(2),
        .LATCH_US(5), .REFRESH_MS(0)
    ) u_dut (
        .clk(clk), .rst(rst), .wscolor(wscolor), .start(start),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .pix_bank(pix_bank), .pix_last(pix_last), .latch(latch),
        .busy(busy), .frame_done(frame_done)
    );

    ws2812_frame_sequencer #(
        .CLKHZ(32'd10_000_000), .BANK_NUM(2), .BANK_X(2), .BANK_Y(2),
        .LATCH_US(5), .REFRESH_MS(1)
    ) u_ref (
        .clk(clk), .rst(rst), .wscolor(wscolor), .start(start_r),
        .pix_valid(pix_valid_r), .pix_ready(1'b1), .pix_data(pix_data_r),
        .pix_bank(pix_bank_r), .pix_last(pix_last_r), .latch(latch_r),
        .busy(busy_r), .frame_done(frame_done_r)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic init_colors();
        for (int i = 0; i < 8; i++) wscolor[i] = 24'(32'h010203 * (i + 1));
    endtask

    // One full frame from a start pulse; compares every word against the table.
    task automatic run_frame(input bit use_stall, input bit poke_start, input bit corrupt);
        int n;
        int st;
        int d0;
        d0 = done_cnt;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("valid_after_start", pix_valid, 0);
        for (int k = 0; k < 8; k++) begin
            st = use_stall ? tab[k].stall : 0;
            if (st > 0) pix_ready = 1'b0;
            n = 0;
            while (!pix_valid && n < 8) begin
                step();
                n++;
            end
            chk($sformatf("load_cycles_px%0d", k), n, 1);
            chk($sformatf("data_px%0d", k), pix_data, tab[k].data);
            chk($sformatf("bank_px%0d", k), pix_bank, tab[k].bank);
            chk($sformatf("last_px%0d", k), pix_last, tab[k].last);
            for (int s = 1; s < st; s++) begin
                if (corrupt && k == 0 && s == 1) wscolor[0] = 24'hFFFFFF;
                step();
                chk($sformatf("hold_valid_px%0d_c%0d", k, s), pix_valid, 1);
                chk($sformatf("hold_data_px%0d_c%0d", k, s), pix_data, tab[k].data);
            end
            pix_ready = 1'b1;
            if (poke_start && k == 1) start = 1'b1;
            step();
            start = 1'b0;
        end
        chk("latch_after_last", latch, 1);
        n = 0;
        while (latch && n < 200) begin
            n++;
            if (poke_start && n == 10) start = 1'b1;
            step();
            start = 1'b0;
        end
        chk("latch_len", n, 50);
        chk("frame_done_pulse", frame_done, 1);
        chk("busy_in_done", busy, 1);
        step();
        chk("frame_done_off", frame_done, 0);
        chk("busy_back_low", busy, 0);
        if (poke_start) begin
            repeat (80) step();
            chk("no_queued_frame_busy", busy, 0);
        end
        chk("done_count", done_cnt - d0, 1);
    endtask

    task automatic wait_rise_r(input int budget, output int c);
        int n;
        n = 0;
        c = -1;
        while (busy_r && n < budget) begin step(); n++; end
        while (!busy_r && n < budget) begin step(); n++; end
        if (busy_r) c = cyc;
        else chk("refresh_rise_timeout", 0, 1);
    endtask

    initial begin
        int n;
        int d0;
        int c1, c2, c3, ra, rb;

        // {stall, expected GRB word, bank, last}; wscolor[i] = 010203*(i+1)
        tab[0] = '{3, 24'h020103, 1'b0, 1'b0};
        tab[1] = '{0, 24'h040206, 1'b0, 1'b0};
        tab[2] = '{7, 24'h060309, 1'b0, 1'b0};
        tab[3] = '{0, 24'h08040C, 1'b0, 1'b1};
        tab[4] = '{0, 24'h0A050F, 1'b1, 1'b0};
        tab[5] = '{0, 24'h0C0612, 1'b1, 1'b0};
        tab[6] = '{0, 24'h0E0715, 1'b1, 1'b0};
        tab[7] = '{0, 24'h100818, 1'b1, 1'b1};

        init_colors();
        repeat (3) step();
        chk("rst_valid", pix_valid, 0);
        chk("rst_data", pix_data, 0);
        chk("rst_bank", pix_bank, 0);
        chk("rst_last", pix_last, 0);
        chk("rst_latch", latch, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        rst = 1'b0;
        step();

        run_frame(1'b0, 1'b0, 1'b0);    // plain frame, ready tied high
        run_frame(1'b1, 1'b0, 1'b1);    // stalls on px0/px2, wscolor[0] overwritten while held
        init_colors();
        run_frame(1'b0, 1'b1, 1'b0);    // start re-pulsed in SEND and LATCH

        // Reset in the middle of a frame, while pixel 3 is on the bus.
        d0 = done_cnt;
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (!(pix_valid && pix_data == 24'h08040C) && n < 40) begin step(); n++; end
        chk("rst_reach_px3", pix_data, 24'h08040C);
        rst = 1'b1;
        step();
        chk("midrst_valid", pix_valid, 0);
        chk("midrst_data", pix_data, 0);
        chk("midrst_bank", pix_bank, 0);
        chk("midrst_last", pix_last, 0);
        chk("midrst_latch", latch, 0);
        chk("midrst_busy", busy, 0);
        rst = 1'b0;
        repeat (80) step();
        chk("midrst_no_done", done_cnt - d0, 0);
        run_frame(1'b0, 1'b0, 1'b0);

        // Auto-refresh instance: 1 ms at 10 MHz.
        wait_rise_r(25000, c1);
        wait_rise_r(12000, c2);
        chk("refresh_period", c2 - c1, 10000);
        while (cyc < c2 + 9980) step();
        chk("refresh_idle_before_start", busy_r, 0);
        start_r = 1'b1;
        step();
        start_r = 1'b0;
        chk("refresh_start_busy", busy_r, 1);
        ra = cyc;
        d0 = done_r_cnt;
        wait_rise_r(300, rb);
        chk("tick_serviced_after_done", rb - ra, 68);
        while (cyc < c2 + 19000) step();
        chk("tick_serviced_once", done_r_cnt - d0, 2);
        wait_rise_r(2000, c3);
        chk("refresh_period_kept", c3 - c2, 20000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
